// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-event bundle. The scan controller drives the master side;
// the keypad pins and the number-entry consumer are on the slave side.
interface keypad_scan_ctrl_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;

  modport master (
    input  col_n,
    input  key_ready,
    output row_n,
    output key_code,
    output key_valid,
    output key_held,
    output overflow
  );

  modport slave (
    output col_n,
    output key_ready,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overflow
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: dwell-timed row strobes, full-matrix debounce, chord
// rejection and a small valid/ready queue of single-key press events.
module keypad_scan_ctrl #(
  parameter int DWELL      = 4,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  keypad_scan_ctrl_if.master kp
);

  localparam int DW = $clog2(DWELL);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  logic [DW-1:0] dwell_cnt;
  logic [1:0]    row_idx;
  logic [15:0]   snapshot;
  logic          scan_done;
  logic [15:0]   prev_snap;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_next;
  logic [15:0]   deb_state;
  logic          held;
  logic          same_snap;
  logic          deb_update;
  logic          new_event;
  logic [3:0]    snap_code;
  logic          push_req;
  logic [3:0]    push_code;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow_q;
  logic          pop;
  logic          do_push;

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      row_idx   <= 2'd0;
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (dwell_cnt == DWELL_LAST) begin
        dwell_cnt                      <= '0;
        snapshot[{row_idx, 2'b00} +: 4] <= ~kp.col_n;
        row_idx                        <= row_idx + 2'd1;
        scan_done                      <= (row_idx == 2'd3);
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
    end
  end

  assign kp.row_n = ~(4'b0001 << row_idx);

  // A differing snapshot also counts as an update when a single scan suffices.
  always_comb begin
    same_snap   = (snapshot == prev_snap);
    stable_next = SW'(1);
    if (same_snap) begin
      stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + SW'(1);
    end
    deb_update = scan_done && (stable_next == STABLE_MAX) &&
                 ((stable_cnt != STABLE_MAX) || !same_snap);
    new_event  = deb_update && is_onehot(snapshot) &&
                 ((deb_state == 16'd0) || is_onehot(deb_state)) &&
                 (snapshot != deb_state);
    snap_code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) snap_code = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snap  <= '0;
      stable_cnt <= '0;
      deb_state  <= '0;
      held       <= 1'b0;
      push_req   <= 1'b0;
      push_code  <= 4'd0;
    end else begin
      push_req  <= new_event;
      push_code <= snap_code;
      if (scan_done) begin
        stable_cnt <= stable_next;
        prev_snap  <= snapshot;
      end
      if (deb_update) begin
        deb_state <= snapshot;
        held      <= is_onehot(snapshot);
      end
    end
  end

  // A pop frees the slot a simultaneous push into a full queue needs.
  assign pop     = (count != '0) && kp.key_ready;
  assign do_push = push_req && ((count != FULL_CNT) || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_req && !do_push) overflow_q <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign kp.key_valid = (count != '0);
  assign kp.key_code  = kp.key_valid ? mem[rd_ptr] : 4'd0;
  assign kp.key_held  = held;
  assign kp.overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model feeds the columns and a
// scoreboard of expected key codes is checked against every accepted event.
module tb_keypad_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pressed;
  int          vectors     = 0;
  int          miscompares = 0;
  int          pop_cnt     = 0;
  int          sb[$];

  keypad_scan_ctrl_if kp();

  keypad_scan_ctrl #(.DWELL(4), .DEBOUNCE(3), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;

  // Closed keys on the strobed row pull their column low.
  always_comb begin
    kp.col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!kp.row_n[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r*4 + c]) kp.col_n[c] = 1'b0;
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Every accepted handshake is matched against the oldest expected code.
  always begin
    int exp_code;
    @(negedge clk);
    #2;
    if (!rst && kp.key_valid && kp.key_ready) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        check_output("extra_event", 1, 0);
      end else begin
        exp_code = sb.pop_front();
        check_output("key_code", kp.key_code, exp_code);
      end
    end
  end

  task automatic wait_scan_end();
    logic [3:0] prev;
    bit         seen;
    prev = kp.row_n;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && kp.row_n == 4'b1110) seen = 1;
      prev = kp.row_n;
    end
    if (!seen) check_output("scan_timeout", 0, 1);
  endtask

  task automatic run_scans(input logic [15:0] m, input int n);
    pressed = m;
    repeat (n) wait_scan_end();
    repeat (2) @(negedge clk);
  endtask

  // Third qualifying scan: key_valid must rise exactly two clocks after it.
  task automatic expect_event(input int code);
    wait_scan_end();
    check_output("lat_e0_valid", kp.key_valid, 0);
    @(negedge clk);
    check_output("lat_e1_valid", kp.key_valid, 0);
    check_output("lat_e1_held", kp.key_held, 1);
    @(negedge clk);
    check_output("lat_e2_valid", kp.key_valid, 1);
    check_output("lat_e2_code", kp.key_code, code);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          pc;
    logic [3:0]  exp_row;

    rst          = 1'b1;
    pressed      = 16'd0;
    kp.key_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset and idle row rotation");
    check_output("rst_valid", kp.key_valid, 0);
    check_output("rst_held", kp.key_held, 0);
    check_output("rst_overflow", kp.overflow, 0);
    check_output("rst_code", kp.key_code, 0);
    for (int k = 0; k < 20; k++) begin
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check_output("row_n", kp.row_n, exp_row);
      check_output("idle_valid", kp.key_valid, 0);
      @(negedge clk);
    end

    $display("[TB] single key 6");
    wait_scan_end();
    pressed = 16'd1 << 6;
    sb.push_back(6);
    wait_scan_end();
    wait_scan_end();
    expect_event(6);
    kp.key_ready = 1'b1;
    @(negedge clk);
    check_output("pop_once_valid", kp.key_valid, 0);
    run_scans(16'd1 << 6, 4);
    check_output("no_repeat_valid", kp.key_valid, 0);
    check_output("no_repeat_pops", pop_cnt, 1);
    run_scans(16'd0, 3);
    check_output("release_held", kp.key_held, 0);

    $display("[TB] bounce on key 9");
    pc = pop_cnt;
    sb.push_back(9);
    run_scans(16'd1 << 9, 1);
    run_scans(16'd0, 1);
    run_scans(16'd1 << 9, 2);
    check_output("bounce_early_valid", kp.key_valid, 0);
    check_output("bounce_early_pops", pop_cnt, pc);
    wait_scan_end();
    repeat (4) @(negedge clk);
    check_output("bounce_pops", pop_cnt, pc + 1);
    run_scans(16'd0, 3);

    $display("[TB] chord 0+5, then key 15");
    pc = pop_cnt;
    run_scans((16'd1 << 0) | (16'd1 << 5), 5);
    check_output("chord_held", kp.key_held, 0);
    check_output("chord_valid", kp.key_valid, 0);
    run_scans(16'd1 << 5, 4);
    check_output("chord_single_held", kp.key_held, 1);
    check_output("chord_single_pops", pop_cnt, pc);
    run_scans(16'd0, 3);
    sb.push_back(15);
    run_scans(16'd1 << 15, 3);
    repeat (4) @(negedge clk);
    check_output("key15_pops", pop_cnt, pc + 1);
    run_scans(16'd0, 3);

    $display("[TB] queue overflow");
    kp.key_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) sb.push_back(k);
      run_scans(16'd1 << k, 3);
      run_scans(16'd0, 3);
      if (k == 4) check_output("full_no_overflow", kp.overflow, 0);
    end
    check_output("overflow_set", kp.overflow, 1);
    check_output("full_valid", kp.key_valid, 1);
    kp.key_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_output("drain_sb", sb.size(), 0);
    check_output("drain_valid", kp.key_valid, 0);
    check_output("overflow_sticky", kp.overflow, 1);

    $display("[TB] reset mid-debounce with queued events");
    kp.key_ready = 1'b0;
    run_scans(16'd1 << 7, 3);
    run_scans(16'd0, 3);
    run_scans(16'd1 << 8, 3);
    check_output("pre_rst_valid", kp.key_valid, 1);
    pressed = 16'd1 << 11;
    wait_scan_end();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("mid_rst_row", kp.row_n, 4'b1110);
    check_output("mid_rst_valid", kp.key_valid, 0);
    check_output("mid_rst_overflow", kp.overflow, 0);
    check_output("mid_rst_held", kp.key_held, 0);
    kp.key_ready = 1'b1;
    sb.push_back(11);
    wait_scan_end();
    wait_scan_end();
    expect_event(11);
    repeat (4) @(negedge clk);
    check_output("final_sb", sb.size(), 0);
    check_output("final_valid", kp.key_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
